// File: rtl/run_monitor_pkg.sv
// Shared types and widths for the run monitor: FSM states, verdict encoding,
// channel width and check-index width.
package run_monitor_pkg;

   localparam int unsigned CHW  = 32;
   localparam int unsigned IDXW = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CHECK,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      V_NONE,
      V_PASS,
      V_FAIL,
      V_TIMEOUT
   } verdict_t;

endpackage

// File: rtl/run_monitor_if.sv
// Core-side observation bus: program counter plus the memory-write port.
interface run_monitor_if;
   import run_monitor_pkg::*;

   logic [CHW-1:0] pc;
   logic [CHW-1:0] Adr;
   logic [CHW-1:0] WriteData;
   logic           MemWrite;

   modport master (output pc, Adr, WriteData, MemWrite);
   modport slave  (input  pc, Adr, WriteData, MemWrite);

endinterface

// File: rtl/run_monitor_chk_compare.sv
// Parallel register-check comparator. Reports whether all channels match and
// the lowest-numbered mismatching channel.
module chk_compare
   import run_monitor_pkg::*;
#(
   parameter int unsigned NUM_CHK = 2
) (
   input  logic [NUM_CHK*CHW-1:0] chk_data,
   input  logic [NUM_CHK*CHW-1:0] chk_expect,
   output logic                   all_match,
   output logic [IDXW-1:0]        first_mismatch
);

   logic [NUM_CHK-1:0] mismatch;

   always_comb begin
      mismatch = '0;
      for (int i = 0; i < NUM_CHK; i++) begin
         mismatch[i] = (chk_data[i*CHW +: CHW] != chk_expect[i*CHW +: CHW]);
      end
   end

   // Scan high to low so the lowest mismatching index is the final winner.
   always_comb begin
      first_mismatch = '0;
      for (int i = NUM_CHK - 1; i >= 0; i--) begin
         if (mismatch[i]) first_mismatch = IDXW'(i);
      end
   end

   assign all_match = ~|mismatch;

endmodule

// File: rtl/run_monitor.sv
// Run controller and sticky verdict engine: cycle budget, mailbox store
// detection, PC-stall halt detection followed by a one-cycle register check.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int unsigned    TIMEOUT_CYCLES = 1000,
   parameter int unsigned    STALL_LIMIT    = 16,
   parameter logic [CHW-1:0] MAILBOX_ADDR   = 32'h0000_00FC,
   parameter logic [CHW-1:0] PASS_VALUE     = 32'd1,
   parameter int unsigned    NUM_CHK        = 2,
   parameter int unsigned    CW             = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run_en,
   input  logic                   clear,
   run_monitor_if.slave           bus,
   input  logic [NUM_CHK*CHW-1:0] chk_data,
   input  logic [NUM_CHK*CHW-1:0] chk_expect,
   output logic [CW-1:0]          cycles,
   output logic                   done,
   output logic                   pass,
   output logic                   fail,
   output logic                   timeout,
   output logic [CHW-1:0]         fail_code
);

   localparam int unsigned SW = $clog2(STALL_LIMIT) + 1;

   state_t         state_q, state_n;
   verdict_t       verdict_q, verdict_n;
   logic [SW-1:0]  stall_q, stall_n;
   logic [CHW-1:0] last_pc_q, last_pc_n;
   logic [CW-1:0]  cycles_n;
   logic [CHW-1:0] code_n;

   logic            all_match;
   logic [IDXW-1:0] first_mismatch;

   chk_compare #(.NUM_CHK(NUM_CHK)) u_cmp (
      .chk_data       (chk_data),
      .chk_expect     (chk_expect),
      .all_match      (all_match),
      .first_mismatch (first_mismatch)
   );

   logic          mailbox_hit, pc_same, halt_hit, timeout_hit, cyc_sat;
   logic [CW-1:0] cycles_inc;

   assign mailbox_hit = bus.MemWrite && (bus.Adr == MAILBOX_ADDR);
   assign pc_same     = (bus.pc == last_pc_q);
   assign halt_hit    = pc_same && (stall_q == SW'(STALL_LIMIT - 1));
   assign cyc_sat     = (cycles == '1);
   assign cycles_inc  = cyc_sat ? cycles : cycles + CW'(1);
   // A saturated counter can never hit the budget, so timeout stays silent.
   assign timeout_hit = !cyc_sat && ((64'(cycles) + 64'd1) == 64'(TIMEOUT_CYCLES));

   always_comb begin
      state_n   = state_q;
      verdict_n = verdict_q;
      stall_n   = stall_q;
      last_pc_n = last_pc_q;
      cycles_n  = cycles;
      code_n    = fail_code;
      if (clear) begin
         state_n   = IDLE;
         verdict_n = V_NONE;
         stall_n   = '0;
         last_pc_n = '0;
         cycles_n  = '0;
         code_n    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (run_en) begin
                  state_n   = RUN;
                  cycles_n  = '0;
                  stall_n   = '0;
                  last_pc_n = bus.pc;
               end
            end
            RUN: begin
               cycles_n = cycles_inc;
               if (pc_same) begin
                  stall_n = stall_q + SW'(1);
               end else begin
                  stall_n   = '0;
                  last_pc_n = bus.pc;
               end
               // Priority: mailbox, then halt, then timeout.
               if (mailbox_hit) begin
                  state_n = DONE;
                  if (bus.WriteData == PASS_VALUE) begin
                     verdict_n = V_PASS;
                     code_n    = '0;
                  end else begin
                     verdict_n = V_FAIL;
                     code_n    = bus.WriteData;
                  end
               end else if (halt_hit) begin
                  state_n = CHECK;
               end else if (timeout_hit) begin
                  state_n   = DONE;
                  verdict_n = V_TIMEOUT;
                  code_n    = '0;
               end
            end
            CHECK: begin
               state_n = DONE;
               if (all_match) begin
                  verdict_n = V_PASS;
                  code_n    = '0;
               end else begin
                  verdict_n = V_FAIL;
                  code_n    = CHW'(first_mismatch);
               end
            end
            DONE: begin
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         verdict_q <= V_NONE;
         stall_q   <= '0;
         last_pc_q <= '0;
         cycles    <= '0;
         fail_code <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state_q   <= state_n;
         verdict_q <= verdict_n;
         stall_q   <= stall_n;
         last_pc_q <= last_pc_n;
         cycles    <= cycles_n;
         fail_code <= code_n;
         done      <= (verdict_n != V_NONE);
         pass      <= (verdict_n == V_PASS);
         fail      <= (verdict_n == V_FAIL);
         timeout   <= (verdict_n == V_TIMEOUT);
      end
   end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: mailbox pass/fail, halt check, timeout,
// event priority, clear and asynchronous reset.
module tb_run_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run_en = 1'b0;
   logic        clear = 1'b0;
   logic [63:0] chk_data;
   logic [63:0] chk_expect;
   logic [31:0] cycles;
   logic [31:0] fail_code;
   logic        done, pass, fail, timeout;
   logic        hold_pc = 1'b0;
   int          errors = 0;
   int          checks = 0;

   run_monitor_if bus();

   run_monitor #(
      .TIMEOUT_CYCLES (1000),
      .STALL_LIMIT    (16),
      .MAILBOX_ADDR   (32'h0000_00FC),
      .PASS_VALUE     (32'd1),
      .NUM_CHK        (2),
      .CW             (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run_en     (run_en),
      .clear      (clear),
      .bus        (bus),
      .chk_data   (chk_data),
      .chk_expect (chk_expect),
      .cycles     (cycles),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .fail_code  (fail_code)
   );

   always #5 clk = ~clk;

   // One clock: sample point is 1 ns after the edge; pc moves unless held.
   task automatic tick();
      @(posedge clk);
      #1;
      if (!hold_pc) bus.pc = bus.pc + 32'd4;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      bus.Adr = a; bus.WriteData = d; bus.MemWrite = 1'b1;
      tick();
      bus.MemWrite = 1'b0; bus.Adr = 32'h0;
   endtask

   task automatic start_run();
      run_en = 1'b1;
      tick();
      run_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      #18;
      checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
      checks++; if ({done, pass, fail, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {done, pass, fail, timeout}); end
      checks++; if (fail_code !== 32'd0) begin errors++; $display("FAIL reset_code: got %h want 0", fail_code); end
      #4 reset = 1'b0;
   endtask

   task automatic test_mailbox_pass();
      start_run();
      for (int i = 1; i <= 39; i++) begin
         if (i == 10) begin
            bus.Adr = 32'hF8; bus.WriteData = 32'd1; bus.MemWrite = 1'b1;
         end else if (i == 11) begin
            bus.Adr = 32'hFC; bus.WriteData = 32'd1; bus.MemWrite = 1'b0;
         end else begin
            bus.MemWrite = 1'b0;
         end
         tick();
      end
      bus.MemWrite = 1'b0;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_ignored_store: done=%b want 0", done); end
      checks++; if (cycles !== 32'd39) begin errors++; $display("FAIL pass_pre_cycles: got %0d want 39", cycles); end
      do_store(32'hFC, 32'd1);
      checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++; $display("FAIL pass_flags: got %b want 1100", {done, pass, fail, timeout}); end
      checks++; if (cycles !== 32'd40) begin errors++; $display("FAIL pass_cycles: got %0d want 40", cycles); end
      checks++; if (fail_code !== 32'd0) begin errors++; $display("FAIL pass_code: got %h want 0", fail_code); end
      run_ticks(5);
      checks++; if (cycles !== 32'd40 || pass !== 1'b1) begin errors++; $display("FAIL pass_hold: cycles=%0d pass=%b want 40/1", cycles, pass); end
   endtask

   task automatic test_mailbox_fail();
      do_clear();
      start_run();
      run_ticks(11);
      do_store(32'hFC, 32'h0000_DEAD);
      checks++; if ({done, pass, fail, timeout} !== 4'b1010) begin errors++; $display("FAIL mfail_flags: got %b want 1010", {done, pass, fail, timeout}); end
      checks++; if (fail_code !== 32'h0000_DEAD) begin errors++; $display("FAIL mfail_code: got %h want 0000dead", fail_code); end
      checks++; if (cycles !== 32'd12) begin errors++; $display("FAIL mfail_cycles: got %0d want 12", cycles); end
      do_store(32'hFC, 32'd1);
      run_ticks(2);
      checks++; if ({pass, fail} !== 2'b01 || fail_code !== 32'h0000_DEAD) begin errors++; $display("FAIL mfail_sticky: pass=%b fail=%b code=%h want 0/1/dead", pass, fail, fail_code); end
      checks++; if (cycles !== 32'd12) begin errors++; $display("FAIL mfail_cycles_hold: got %0d want 12", cycles); end
   endtask

   task automatic test_halt(input logic [63:0] expv, input logic exp_pass, input logic [31:0] exp_code);
      chk_data   = {32'd5, 32'd1};
      chk_expect = expv;
      do_clear();
      start_run();
      run_ticks(29);
      hold_pc = 1'b1;
      bus.pc  = 32'h48;
      run_ticks(16);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_early: done=%b want 0", done); end
      tick();
      checks++; if (done !== 1'b0 || cycles !== 32'd46) begin errors++; $display("FAIL halt_check_state: done=%b cycles=%0d want 0/46", done, cycles); end
      tick();
      checks++; if ({done, pass, fail, timeout} !== {1'b1, exp_pass, ~exp_pass, 1'b0}) begin errors++; $display("FAIL halt_flags: got %b want %b", {done, pass, fail, timeout}, {1'b1, exp_pass, ~exp_pass, 1'b0}); end
      checks++; if (fail_code !== exp_code) begin errors++; $display("FAIL halt_code: got %h want %h", fail_code, exp_code); end
      checks++; if (cycles !== 32'd46) begin errors++; $display("FAIL halt_cycles: got %0d want 46", cycles); end
      hold_pc = 1'b0;
   endtask

   task automatic test_timeout();
      do_clear();
      start_run();
      run_ticks(999);
      checks++; if (done !== 1'b0 || cycles !== 32'd999) begin errors++; $display("FAIL to_pre: done=%b cycles=%0d want 0/999", done, cycles); end
      tick();
      checks++; if ({done, pass, fail, timeout} !== 4'b1001) begin errors++; $display("FAIL to_flags: got %b want 1001", {done, pass, fail, timeout}); end
      checks++; if (cycles !== 32'd1000) begin errors++; $display("FAIL to_cycles: got %0d want 1000", cycles); end
      do_store(32'hFC, 32'h0000_0BAD);
      run_ticks(3);
      checks++; if ({done, pass, fail, timeout} !== 4'b1001 || fail_code !== 32'd0) begin errors++; $display("FAIL to_hold: flags=%b code=%h want 1001/0", {done, pass, fail, timeout}, fail_code); end
      checks++; if (cycles !== 32'd1000) begin errors++; $display("FAIL to_cycles_hold: got %0d want 1000", cycles); end
   endtask

   task automatic test_priority_clear();
      do_clear();
      checks++; if ({done, pass, fail, timeout} !== 4'b0000 || cycles !== 32'd0) begin errors++; $display("FAIL clr_from_done: flags=%b cycles=%0d want 0000/0", {done, pass, fail, timeout}, cycles); end
      start_run();
      run_ticks(999);
      do_store(32'hFC, 32'd1);
      checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++; $display("FAIL prio_flags: got %b want 1100", {done, pass, fail, timeout}); end
      checks++; if (cycles !== 32'd1000) begin errors++; $display("FAIL prio_cycles: got %0d want 1000", cycles); end
      do_clear();
      checks++; if ({done, pass, fail, timeout} !== 4'b0000 || cycles !== 32'd0 || fail_code !== 32'd0) begin errors++; $display("FAIL clr_outputs: flags=%b cycles=%0d code=%h want zeros", {done, pass, fail, timeout}, cycles, fail_code); end
      run_ticks(5);
      checks++; if (cycles !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL clr_idle: cycles=%0d done=%b want 0/0", cycles, done); end
      start_run();
      run_ticks(3);
      clear = 1'b1;
      do_store(32'hFC, 32'd1);
      clear = 1'b0;
      checks++; if (done !== 1'b0 || cycles !== 32'd0) begin errors++; $display("FAIL clr_over_mailbox: done=%b cycles=%0d want 0/0", done, cycles); end
   endtask

   task automatic test_async_reset();
      start_run();
      run_ticks(500);
      checks++; if (cycles !== 32'd500) begin errors++; $display("FAIL ar_pre_cycles: got %0d want 500", cycles); end
      #3 reset = 1'b1;
      #1;
      checks++; if (cycles !== 32'd0 || {done, pass, fail, timeout} !== 4'b0000) begin errors++; $display("FAIL ar_immediate: cycles=%0d flags=%b want 0/0000", cycles, {done, pass, fail, timeout}); end
      #2 reset = 1'b0;
      run_ticks(20);
      checks++; if (cycles !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL ar_no_rerun: cycles=%0d done=%b want 0/0", cycles, done); end
      start_run();
      run_ticks(2);
      do_store(32'hFC, 32'd1);
      checks++; if (pass !== 1'b1 || cycles !== 32'd3) begin errors++; $display("FAIL ar_new_run: pass=%b cycles=%0d want 1/3", pass, cycles); end
   endtask

   initial begin
      bus.pc        = 32'h0000_1000;
      bus.Adr       = 32'h0;
      bus.WriteData = 32'h0;
      bus.MemWrite  = 1'b0;
      chk_data      = {32'd5, 32'd1};
      chk_expect    = {32'd5, 32'd1};
      test_reset();
      test_mailbox_pass();
      test_mailbox_fail();
      test_halt({32'd5, 32'd1}, 1'b1, 32'd0);
      test_halt({32'd6, 32'd1}, 1'b0, 32'd1);
      test_halt({32'd6, 32'd2}, 1'b0, 32'd0);
      test_timeout();
      test_priority_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
